// File: rtl/sequence_generator_if.sv
// Bit-serial link bundle between sequence_generator and its consumer.
// The slave modport is the generator side; the master modport drives the start command.
interface sequence_generator_if #(
   parameter int WIDTH = 6
);
   logic             i_start;
   logic [7:0]       i_repeat;
   logic [3:0]       i_gap;
   logic             o_data;
   logic             o_bit_valid;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_count;
   logic             o_count_end;

   modport slave (
      input  i_start,
      input  i_repeat,
      input  i_gap,
      output o_data,
      output o_bit_valid,
      output o_busy,
      output o_done,
      output o_count,
      output o_count_end
   );

   modport master (
      output i_start,
      output i_repeat,
      output i_gap,
      input  o_data,
      input  o_bit_valid,
      input  o_busy,
      input  o_done,
      input  o_count,
      input  o_count_end
   );
endinterface

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: bursts of PATTERN (MSB first) with programmable repeats and gaps.
// Optional macro SEQ_GEN_LFSR_FILL_EN replaces the constant-0 fill bit with a 7-bit LFSR.
module sequence_generator #(
   parameter int                 PAT_LEN = 6,
   parameter logic [PAT_LEN-1:0] PATTERN = 6'b101001,
   parameter int                 WIDTH   = 6
) (
   input  logic                 i_clk,
   input  logic                 i_resetn,
   sequence_generator_if.slave  bus
);

   localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       rem_q, rem_d;
   logic [3:0]       gap_q, gap_d;
   logic [3:0]       gcnt_q, gcnt_d;
   logic             data_q, data_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             count_end_q, count_end_d;
   logic             fill_s;

`ifdef SEQ_GEN_LFSR_FILL_EN
   logic [6:0] lfsr_q;
   logic [6:0] lfsr_d;

   // x^7+x^6+1 Fibonacci LFSR; frozen while pattern bits are on the wire
   always_comb begin
      if (state_q != ST_SEND) begin
         lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
      end else begin
         lfsr_d = lfsr_q;
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         lfsr_q <= 7'h01;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign fill_s = lfsr_q[6];
`else
   assign fill_s = 1'b0;
`endif

   // idx_q names the bit currently presented on o_data
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      rem_d       = rem_q;
      gap_d       = gap_q;
      gcnt_d      = gcnt_q;
      data_d      = fill_s;
      valid_d     = 1'b0;
      done_d      = 1'b0;
      count_d     = count_q;
      count_end_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.i_start) begin
               if (bus.i_repeat == 8'd0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  rem_d   = bus.i_repeat;
                  gap_d   = bus.i_gap;
                  idx_d   = LAST_IDX;
                  data_d  = PATTERN[LAST_IDX];
                  valid_d = 1'b1;
                  state_d = ST_SEND;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SEND: begin
            if (idx_q != {IDX_W{1'b0}}) begin
               idx_d   = idx_q - IDX_W'(1);
               data_d  = PATTERN[idx_q - IDX_W'(1)];
               valid_d = 1'b1;
            end else begin
               count_d     = count_q + WIDTH'(1);
               count_end_d = (count_q == {WIDTH{1'b1}});
               rem_d       = rem_q - 8'd1;
               if (rem_q == 8'd1) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else if (gap_q != 4'd0) begin
                  state_d = ST_GAP;
                  gcnt_d  = gap_q;
               end else begin
                  idx_d   = LAST_IDX;
                  data_d  = PATTERN[LAST_IDX];
                  valid_d = 1'b1;
               end
            end
         end

         ST_GAP: begin
            // gcnt_q counts the fill cycles still to be shown, including this one
            if (gcnt_q == 4'd1) begin
               gcnt_d  = 4'd0;
               idx_d   = LAST_IDX;
               data_d  = PATTERN[LAST_IDX];
               valid_d = 1'b1;
               state_d = ST_SEND;
            end else begin
               gcnt_d = gcnt_q - 4'd1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and every output are registered together
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state_q     <= ST_IDLE;
         idx_q       <= {IDX_W{1'b0}};
         rem_q       <= 8'd0;
         gap_q       <= 4'd0;
         gcnt_q      <= 4'd0;
         data_q      <= 1'b0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         count_q     <= {WIDTH{1'b0}};
         count_end_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         rem_q       <= rem_d;
         gap_q       <= gap_d;
         gcnt_q      <= gcnt_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         count_q     <= count_d;
         count_end_q <= count_end_d;
      end
   end

   assign bus.o_data      = data_q;
   assign bus.o_bit_valid = valid_q;
   assign bus.o_busy      = busy_q;
   assign bus.o_done      = done_q;
   assign bus.o_count     = count_q;
   assign bus.o_count_end = count_end_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: a per-cycle expected trace is built from the burst rules.
module tb_sequence_generator;

   typedef struct packed {
      logic       v;
      logic       d;
      logic       b;
      logic       dn;
      logic       ce;
      logic [5:0] c;
   } cyc_t;

   logic i_clk;
   logic i_resetn;
   int   compared;
   int   mismatched;
   int   m_count;
   logic [5:0] pat_v;
   cyc_t exp_q[$];

   sequence_generator_if #(.WIDTH(6)) bus ();

   sequence_generator #(
      .PAT_LEN (6),
      .PATTERN (6'b101001),
      .WIDTH   (6)
   ) dut (
      .i_clk    (i_clk),
      .i_resetn (i_resetn),
      .bus      (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected trace from the visible cycle after the start edge through the o_done cycle
   task automatic build(input int rep, input int gap);
      logic pend;
      cyc_t e;
      exp_q.delete();
      pend = 1'b0;
      for (int r = 0; r < rep; r++) begin
         for (int b = 0; b < 6; b++) begin
            e = '{v: 1'b1, d: pat_v[5-b], b: 1'b1, dn: 1'b0, ce: pend, c: 6'(m_count)};
            exp_q.push_back(e);
            pend = 1'b0;
         end
         m_count = (m_count + 1) % 64;
         pend    = (m_count == 0);
         if (r < rep - 1) begin
            for (int g = 0; g < gap; g++) begin
               e = '{v: 1'b0, d: 1'b0, b: 1'b1, dn: 1'b0, ce: pend, c: 6'(m_count)};
               exp_q.push_back(e);
               pend = 1'b0;
            end
         end
      end
      e = '{v: 1'b0, d: 1'b0, b: 1'b1, dn: 1'b1, ce: pend, c: 6'(m_count)};
      exp_q.push_back(e);
   endtask

   task automatic check_cycle(input string tag, input cyc_t e);
      chk({tag, " valid"}, 32'(bus.o_bit_valid), 32'(e.v));
`ifndef SEQ_GEN_LFSR_FILL_EN
      chk({tag, " data"}, 32'(bus.o_data), 32'(e.d));
`else
      if (e.v) begin
         chk({tag, " data"}, 32'(bus.o_data), 32'(e.d));
      end
`endif
      chk({tag, " busy"}, 32'(bus.o_busy), 32'(e.b));
      chk({tag, " done"}, 32'(bus.o_done), 32'(e.dn));
      chk({tag, " count_end"}, 32'(bus.o_count_end), 32'(e.ce));
      chk({tag, " count"}, 32'(bus.o_count), 32'(e.c));
   endtask

   // Entered and left at #1 after a rising edge
   task automatic run_burst(input string tag, input int rep, input int gap, input bit noise);
      int busy_cycles;
      build(rep, gap);
      bus.i_start  = 1'b1;
      bus.i_repeat = 8'(rep);
      bus.i_gap    = 4'(gap);
      @(posedge i_clk);
      #1;
      bus.i_start  = 1'b0;
      bus.i_repeat = 8'($urandom);
      bus.i_gap    = 4'($urandom);
      busy_cycles  = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
         check_cycle($sformatf("%s cyc%0d", tag, k + 1), exp_q[k]);
         if (bus.o_busy === 1'b1) busy_cycles++;
         bus.i_start = (noise && (k < exp_q.size() - 1)) ? 1'($urandom) : 1'b0;
         @(posedge i_clk);
         #1;
      end
      bus.i_start = 1'b0;
      chk({tag, " busy_cycles"}, 32'(busy_cycles),
          32'((rep == 0) ? 1 : rep * 6 + (rep - 1) * gap + 1));
      chk({tag, " idle busy"}, 32'(bus.o_busy), 32'd0);
      chk({tag, " idle done"}, 32'(bus.o_done), 32'd0);
      chk({tag, " idle valid"}, 32'(bus.o_bit_valid), 32'd0);
      chk({tag, " idle count"}, 32'(bus.o_count), 32'(m_count));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " data"}, 32'(bus.o_data), 32'd0);
      chk({tag, " valid"}, 32'(bus.o_bit_valid), 32'd0);
      chk({tag, " busy"}, 32'(bus.o_busy), 32'd0);
      chk({tag, " done"}, 32'(bus.o_done), 32'd0);
      chk({tag, " count"}, 32'(bus.o_count), 32'd0);
      chk({tag, " count_end"}, 32'(bus.o_count_end), 32'd0);
   endtask

   initial begin
      compared     = 0;
      mismatched   = 0;
      m_count      = 0;
      pat_v        = 6'b101001;
      bus.i_start  = 1'b0;
      bus.i_repeat = 8'd0;
      bus.i_gap    = 4'd0;
      i_resetn     = 1'b0;

      repeat (3) @(posedge i_clk);
      #1;
      check_all_zero("reset");
      i_resetn = 1'b1;
      @(posedge i_clk);
      #1;
      chk("post-reset busy", 32'(bus.o_busy), 32'd0);

      run_burst("t1 rep1", 1, 0, 1'b0);
      run_burst("t2 rep3", 3, 0, 1'b0);
      run_burst("t3 rep2 gap3", 2, 3, 1'b0);
      run_burst("t4 rep0", 0, 0, 1'b0);

      // Start mid-SEND is ignored, then an asynchronous reset aborts the burst
      build(3, 1);
      bus.i_start  = 1'b1;
      bus.i_repeat = 8'd3;
      bus.i_gap    = 4'd1;
      @(posedge i_clk);
      #1;
      bus.i_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check_cycle($sformatf("t5 cyc%0d", k + 1), exp_q[k]);
         bus.i_start = (k == 1) ? 1'b1 : 1'b0;
         @(posedge i_clk);
         #1;
      end
      bus.i_start = 1'b0;
      check_cycle("t5 cyc4", exp_q[3]);
      #2;
      i_resetn = 1'b0;
      #1;
      check_all_zero("t5 async reset");
      m_count = 0;
      for (int k = 0; k < 2; k++) begin
         @(posedge i_clk);
         #1;
         chk("t5 held done", 32'(bus.o_done), 32'd0);
      end
      i_resetn = 1'b1;
      @(posedge i_clk);
      #1;
      check_all_zero("t5 after release");

      for (int n = 0; n < 6; n++) begin
         run_burst($sformatf("rnd%0d", n), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 5)), 1'b1);
      end

      run_burst("t6 rep64", 64, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
Serial pattern transmitter that drives the single-bit data input of sequence_detector, making it the sending end of the same bit-serial link. On a start command it emits a fixed PAT_LEN-bit pattern (default 101001) MSB first, repeated a programmable number of times with a programmable idle gap between repeats. It keeps a count of patterns transmitted, mirroring the detector's count output so the bench can compare the two directly.

Parameters:
PATTERN, 6'b101001, bit pattern to transmit, MSB sent first.
PAT_LEN, 6, number of bits in PATTERN (2..32).
WIDTH, 6, width of the transmitted-pattern counter o_count.

Ports:
i_clk  input  1  single system clock; all logic on its rising edge.
i_resetn  input  1  asynchronous, active-low reset.
i_start  input  1  start request; sampled only in IDLE.
i_repeat  input  8  number of pattern repeats; latched on accepted start.
i_gap  input  4  fill cycles between repeats; latched on accepted start.
o_data  output  1  serial bit stream to the detector's i_data.
o_bit_valid  output  1  high while o_data carries a pattern bit.
o_busy  output  1  high whenever state is not IDLE.
o_done  output  1  one-cycle pulse when a burst finishes.
o_count  output  WIDTH  patterns transmitted since reset, modulo 2^WIDTH.
o_count_end  output  1  one-cycle pulse when o_count wraps from all-ones to 0.

Behaviour:
- Reset (async, i_resetn=0): state=IDLE; o_data=0, o_bit_valid=0, o_busy=0, o_done=0, o_count=0, o_count_end=0; internal repeat, gap and bit-index registers cleared. Asserting reset mid-burst aborts the burst immediately with no o_done.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, SEND, GAP, DONE.
- IDLE: o_data=fill bit, o_bit_valid=0. On the edge that samples i_start=1:
  - If i_repeat=0: go to DONE. No bits are sent.
  - Otherwise: latch rem=i_repeat and gap=i_gap, go to SEND, and drive o_data=PATTERN[PAT_LEN-1] with o_bit_valid=1 on that same edge. Latency from start to first bit is 1 cycle.
- SEND: one pattern bit per cycle, bit index decrements from PAT_LEN-1 to 0. On the edge after the last bit (index 0):
  - o_count increments. On a wrap, o_count_end pulses for 1 cycle.
  - rem decrements.
  - If rem becomes 0: go to DONE.
  - Else if gap>0: go to GAP for exactly gap cycles.
  - Else: reload the index and send back-to-back, with no bubble.
- GAP: o_data=fill bit, o_bit_valid=0, gap-cycle counter runs. After gap cycles, return to SEND with the index reloaded.
- DONE: o_done=1 for exactly 1 cycle, then IDLE. o_busy=1 in DONE.
- Burst length in busy cycles = repeat*PAT_LEN + (repeat-1)*gap, plus 1 DONE cycle.
- i_start while o_busy=1 is ignored; i_repeat and i_gap changes mid-burst have no effect.
- o_count is cleared only by reset. A new start does not clear it.
- A start accepted in the same cycle o_done drops is legal: IDLE→SEND takes effect on the next sampled start.

Optional Feature:
- Macro SEQ_GEN_LFSR_FILL_EN.
- Defined: the fill bit (IDLE and GAP) is the output of a 7-bit Fibonacci LFSR, x^7+x^6+1, seeded 7'h01 at reset. The LFSR advances every cycle the state is not SEND, which stresses the detector with random non-pattern bits.
- Undefined: the fill bit is constant 0 and no LFSR logic is built.

Test Plan:
1. Reset, then start with repeat=1, gap=0 → o_data 1,0,1,0,0,1 with o_bit_valid=1 for 6 cycles starting 1 cycle after start; o_done pulses at cycle 7; o_count=1; connected detector reports 1 match.
2. Start with repeat=3, gap=0 → 18 contiguous valid bits (101001 ×3); o_count goes 1,2,3; o_busy high for 19 cycles including DONE.
3. Start with repeat=2, gap=3 → 6 pattern bits, 3 fill cycles with o_data=0 and o_bit_valid=0, 6 pattern bits, then o_done; 16 busy cycles total.
4. Start with repeat=0 → o_done pulses 1 cycle after start; o_bit_valid never rises; o_count unchanged.
5. Pulse i_start during SEND, then assert i_resetn=0 mid-SEND → the extra start is ignored; reset forces all outputs to 0 asynchronously with no o_done; after release, state is IDLE and o_count=0.
6. Send 64 patterns in total (e.g. repeat=64, gap=0) → o_count goes 63→0 with a 1-cycle o_count_end pulse at the wrap; with SEQ_GEN_LFSR_FILL_EN defined, first gap bits match LFSR seed 7'h01 sequence.
